// File: rtl/bus_fabric_if.sv
// Bus bundle between the CPU master port, the fabric and the slave channels.
// The fabric modport sits in the middle: it sees the master requests and drives the slave strobes.
interface bus_fabric_if #(
    parameter int NS = 4,
    parameter int AW = 16,
    parameter int DW = 32
) ();
    logic [AW-1:0]    m_addr;
    logic             m_rd_en;
    logic             m_wr_en;
    logic [DW-1:0]    m_wr_data;
    logic [DW/8-1:0]  m_wr_mask;
    logic [DW-1:0]    m_rd_data;
    logic             m_rd_valid;
    logic             m_err;
    logic             m_busy;
    logic [7:0]       err_count;

    logic [AW-1:0]    s_addr;
    logic [NS-1:0]    s_rd_en;
    logic [NS-1:0]    s_wr_en;
    logic [DW-1:0]    s_wr_data;
    logic [DW/8-1:0]  s_wr_mask;
    logic [NS*DW-1:0] s_rd_data;
    logic [NS-1:0]    s_rd_valid;

    modport master (
        output m_addr, m_rd_en, m_wr_en, m_wr_data, m_wr_mask,
        input  m_rd_data, m_rd_valid, m_err, m_busy, err_count
    );

    modport slave (
        input  s_addr, s_rd_en, s_wr_en, s_wr_data, s_wr_mask,
        output s_rd_data, s_rd_valid
    );

    modport fabric (
        input  m_addr, m_rd_en, m_wr_en, m_wr_data, m_wr_mask,
        output m_rd_data, m_rd_valid, m_err, m_busy, err_count,
        output s_addr, s_rd_en, s_wr_en, s_wr_data, s_wr_mask,
        input  s_rd_data, s_rd_valid
    );
endinterface

// File: rtl/bus_fabric.sv
// Single-master, NS-slave memory-mapped fabric: base/mask decode, one outstanding read
// tracked against a registered slave select, with error responses and a saturating error count.
module bus_fabric #(
    parameter int NS      = 4,
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15,
    parameter logic [NS*AW-1:0] SLV_BASE = {16'h5000, 16'h4000, 16'h8000, 16'h0000},
    parameter logic [NS*AW-1:0] SLV_MASK = {16'hF000, 16'hF000, 16'h8000, 16'hC000}
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_fabric_if.fabric  bus
);

    localparam int SW = (NS > 1) ? $clog2(NS) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t        state;
    logic [SW-1:0] sel;
    logic [TW-1:0] timer;
    logic [7:0]    err_count;
    logic          err_rsp_q;
    logic          err_only_q;

    logic [NS-1:0] hits;
    logic [NS-1:0] hit_onehot;
    logic [SW-1:0] hit_idx;
    logic [AW-1:0] hit_mask;
    logic          hit;
    logic          sel_valid_raw;
    logic [DW-1:0] sel_data;
    logic          in_idle;
    logic          in_wait;
    logic          rd_accept;
    logic          sel_valid;
    logic          timeout_hit;
    logic          err_rsp_d;
    logic          err_only_d;

    always_comb begin
        hits = '0;
        for (int i = 0; i < NS; i++) begin
            hits[i] = ((bus.m_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]);
        end
    end

    // Descending scan so the lowest-index hit is the one left standing.
    always_comb begin
        hit_idx  = '0;
        hit_mask = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (hits[i]) begin
                hit_idx  = SW'(i);
                hit_mask = SLV_MASK[i*AW +: AW];
            end
        end
    end

    always_comb begin
        sel_valid_raw = 1'b0;
        sel_data      = '0;
        for (int i = 0; i < NS; i++) begin
            if (SW'(i) == sel) begin
                sel_valid_raw = bus.s_rd_valid[i];
                sel_data      = bus.s_rd_data[i*DW +: DW];
            end
        end
    end

    assign hit        = |hits;
    assign hit_onehot = hits & ~(hits - NS'(1));
    assign in_idle    = (state == ST_IDLE);
    assign in_wait    = (state == ST_WAIT);

    // A write takes priority over a simultaneous read, so a read is only launched alone.
    assign rd_accept   = in_idle && bus.m_rd_en && !bus.m_wr_en && hit;
    assign sel_valid   = in_wait && sel_valid_raw;
    assign timeout_hit = in_wait && !sel_valid_raw && (timer == TW'(TIMEOUT - 1));

    assign err_rsp_d  = (in_idle && bus.m_rd_en && !bus.m_wr_en && !hit) || timeout_hit;
    assign err_only_d = (in_idle && bus.m_wr_en && (!hit || bus.m_rd_en)) ||
                        (in_wait && (bus.m_rd_en || bus.m_wr_en));

    assign bus.s_addr     = bus.m_addr & ~hit_mask;
    assign bus.s_rd_en    = rd_accept ? hit_onehot : '0;
    assign bus.s_wr_en    = (in_idle && bus.m_wr_en) ? hit_onehot : '0;
    assign bus.s_wr_data  = bus.m_wr_data;
    assign bus.s_wr_mask  = bus.m_wr_mask;

    assign bus.m_busy     = in_wait;
    assign bus.m_rd_valid = err_rsp_q || sel_valid;
    assign bus.m_err      = err_rsp_q || err_only_q;
    assign bus.m_rd_data  = sel_valid ? sel_data : '0;
    assign bus.err_count  = err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sel        <= '0;
            timer      <= '0;
            err_count  <= '0;
            err_rsp_q  <= 1'b0;
            err_only_q <= 1'b0;
        end else begin
            err_rsp_q  <= err_rsp_d;
            err_only_q <= err_only_d;
            // Both error sources may fire together; that is still a single m_err pulse.
            if ((err_rsp_d || err_only_d) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (rd_accept) begin
                        sel   <= hit_idx;
                        timer <= '0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (sel_valid_raw || timeout_hit) begin
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bus_fabric.md
# bus_fabric

Parametrised single-master, NS-slave memory-mapped bus fabric with registered transaction tracking. It sits between the CPU bus port and the peripheral and memory slaves. Slave regions are decoded from base/mask parameters. The fabric holds the selected slave for the life of a read, so the response is routed correctly even if the master address changes. Unmapped accesses, read timeouts and protocol violations produce an error response and are counted.

## Interface
- NS, default 4: number of slave channels, 1..8
- AW, default 16: address width
- DW, default 32: data width, multiple of 8
- TIMEOUT, default 15: maximum WAIT cycles for a read response, ≥1
- SLV_BASE, default {16'h5000,16'h4000,16'h8000,16'h0000}: NS×AW flat vector; slave i base at [i*AW +: AW]
- SLV_MASK, default {16'hF000,16'hF000,16'h8000,16'hC000}: NS×AW flat vector; slave i decode mask
- clk  in  1  bus clock
- rst_n  in  1  asynchronous, active-low reset
- m_addr  in  AW  master byte address
- m_rd_en  in  1  read request, one-cycle pulse
- m_wr_en  in  1  write request, one-cycle pulse
- m_wr_data  in  DW  write data
- m_wr_mask  in  DW/8  byte write enables
- m_rd_data  out  DW  read data, valid with m_rd_valid
- m_rd_valid  out  1  read response strobe
- m_err  out  1  error flag; qualifies m_rd_valid, or pulses alone for a write error
- m_busy  out  1  read outstanding; new requests are not accepted
- err_count  out  8  saturating error counter
- s_addr  out  AW  slave-relative address
- s_rd_en  out  NS  per-slave read strobe
- s_wr_en  out  NS  per-slave write strobe
- s_wr_data  out  DW  broadcast write data
- s_wr_mask  out  DW/8  broadcast byte enables
- s_rd_data  in  NS×DW  slave read data, slave i at [i*DW +: DW]
- s_rd_valid  in  NS  per-slave read valid

## Operation
- Decode: slave i hits when (m_addr & SLV_MASK[i]) == SLV_BASE[i]. The lowest index wins if several hit. "miss" means no slave hits.
- s_addr = m_addr & ~SLV_MASK[hit], combinational. On a miss, s_addr = m_addr. s_wr_data and s_wr_mask pass through.
- States:
  - IDLE: requests are accepted.
  - WAIT: one read outstanding; m_busy=1.
- IDLE, m_rd_en, hit i:
  - s_rd_en[i]=1 in the same cycle.
  - sel<=i, timer<=0, go to WAIT.
- IDLE, m_rd_en, miss:
  - No slave strobe.
  - Next cycle: m_rd_valid=1, m_err=1, m_rd_data=0.
  - Stay in IDLE.
- IDLE, m_wr_en, hit i: s_wr_en[i]=1 in the same cycle. Writes are posted; there is no response.
- IDLE, m_wr_en, miss: m_err pulses alone for one cycle, on the next cycle.
- IDLE, m_rd_en and m_wr_en together:
  - The write is performed.
  - The read is dropped and m_err pulses on the next cycle.
- WAIT, s_rd_valid[sel]=1:
  - m_rd_valid=1 and m_rd_data=s_rd_data[sel] in the same cycle (combinational from registered sel).
  - Go to IDLE.
- WAIT, no valid:
  - If timer==TIMEOUT-1: next cycle m_rd_valid=1, m_err=1, m_rd_data=0; go to IDLE.
  - Otherwise timer++.
- WAIT, m_rd_en or m_wr_en:
  - No s_* strobe is issued.
  - m_err pulses the next cycle; the outstanding read continues.
- s_rd_valid from any slave other than sel, or any s_rd_valid in IDLE, is ignored.
- A late response after a timeout is ignored.
- m_rd_data=0 whenever m_rd_valid=0.
- err_count increments by 1 per m_err pulse and saturates at 255.
- timer width is clog2(TIMEOUT)+1.

## Timing
- Reset (rst_n low, takes effect immediately):
  - state=IDLE, sel=0, timer=0, err_count=0.
  - Registered error response=0, so m_rd_valid=0, m_err=0, m_busy=0.
- Reset mid-WAIT aborts the read; no response is ever issued for it.
- Read latency: request in cycle N, slave valid in cycle N+k (k≥1) gives m_rd_valid in cycle N+k. The fabric adds no cycles.
- Timeout: no valid in cycles N+1..N+TIMEOUT gives the error response in cycle N+TIMEOUT+1.
- A valid arriving in cycle N+TIMEOUT completes normally.
- After a timeout the state is IDLE in cycle N+TIMEOUT+1. A request in that cycle is accepted while the error response is being presented.
- m_busy=1 in every WAIT cycle. The master must hold off new requests while m_busy=1.
- Writes complete in the strobe cycle. A read may be issued the cycle after a write.
- Error pulses are exactly one cycle. Simultaneous error sources in one cycle count once.

## Test plan
- Read 0x0010, slave0 valid 1 cycle later with 0x11223344 → s_addr=0x0010, s_rd_en=4'b0001; m_rd_valid with 0x11223344 in cycle N+1; m_err=0.
- Read 0x5004 then change m_addr to 0x8000 while slave3 delays 3 cycles; slave1 also asserts valid → data from slave3 only; s_addr was 0x0004; slave1 valid ignored.
- Read 0x6000 (unmapped) → no s_rd_en; next cycle m_rd_valid=1, m_err=1, data 0; err_count=1. Write 0x6000 → m_err pulse; err_count=2.
- Read slave2, no response, TIMEOUT=15 → m_busy high for 15 cycles; error response in cycle N+16. A late valid in cycle N+20 produces no m_rd_valid.
- Write 0x8004 with mask 4'b0011 during WAIT → no s_wr_en, m_err pulse; the pending read still completes. rd_en+wr_en together in IDLE → write strobe issued, m_err next cycle.
- Assert rst_n low mid-WAIT → all outputs 0 immediately; a subsequent slave valid is ignored. Force 260 errors → err_count holds at 255.
